mem_responder: RTL and testbench

- Memory-side responder that services load/store requests from the control unit.
- Holds a byte-addressed array and presents 16-bit words in little-endian order: low byte at addr, high byte at addr+1.
- Uses valid/ready request and response channels, so the control unit can stall on memory.
- Each access takes two byte cycles against the single-port byte array.

---
 rtl/mem_responder_if.sv | 35 +++
 rtl/mem_responder.sv | 165 ++++++++++++++++
 tb/tb_mem_responder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// ============================================================================
// Module   : mem_responder_if
// Brief    : Request/response valid-ready channels between the control unit
//            (master) and the memory responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_responder_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [15:0]           req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [15:0]           rsp_rdata;
  logic                  rsp_err;

  // Control unit side: issues requests, consumes responses.
  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Memory side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Brief    : Byte-array memory answering 16-bit little-endian load/store
//            requests over valid/ready channels, one byte per cycle.
//            Optional macro MEM_RESP_ALIGN_CHECK_EN rejects odd addresses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int MEM_BYTES  = 16384,
  parameter int ADDR_WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  mem_responder_if.slave    bus,
  output logic              busy
);

  localparam int MEM_AW = $clog2(MEM_BYTES);
  // Highest legal low-byte address: the high byte must still fit.
  localparam logic [ADDR_WIDTH-1:0] LAST_LO_ADDR = ADDR_WIDTH'(MEM_BYTES - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [15:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  busy_q, busy_d;

  // Byte storage; intentionally never reset.
  logic [7:0]            mem_q [MEM_BYTES];

  logic [ADDR_WIDTH-1:0] addr_hi;
  logic [MEM_AW-1:0]     mem_idx;
  logic [7:0]            mem_rd_byte;
  logic                  mem_we;
  logic [7:0]            mem_wr_byte;
  logic                  req_illegal;

  // Single byte port: low byte address in BYTE0, low+1 in BYTE1.
  always_comb begin
    addr_hi     = addr_q + ADDR_WIDTH'(1);
    mem_idx     = (state_q == BYTE1) ? MEM_AW'(addr_hi) : MEM_AW'(addr_q);
    mem_rd_byte = mem_q[mem_idx];
    mem_we      = write_q && ((state_q == BYTE0) || (state_q == BYTE1));
    mem_wr_byte = (state_q == BYTE1) ? wdata_q[15:8] : wdata_q[7:0];
  end

  // Reject requests whose high byte would fall outside the array.
  always_comb begin
`ifdef MEM_RESP_ALIGN_CHECK_EN
    req_illegal = (bus.req_addr > LAST_LO_ADDR) || bus.req_addr[0];
`else
    req_illegal = (bus.req_addr > LAST_LO_ADDR);
`endif
  end

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = write_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          write_d     = bus.req_write;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (req_illegal) begin
            // Error path skips the byte cycles entirely.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 16'h0000;
          end else begin
            state_d = BYTE0;
          end
        end
      end
      BYTE0: begin
        if (!write_q) rsp_rdata_d[7:0] = mem_rd_byte;
        state_d = BYTE1;
      end
      BYTE1: begin
        if (!write_q) rsp_rdata_d[15:8] = mem_rd_byte;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = 16'h0000;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= 16'h0000;
      write_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      write_q     <= write_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  // Byte write port; state is IDLE under reset so no write can occur then.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_idx] <= mem_wr_byte;
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Directed self-checking bench for mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_responder;

  logic clk;
  logic reset_n;
  logic busy;
  int   checks;
  int   failures;

  mem_responder_if #(.ADDR_WIDTH(16)) bus ();

  mem_responder #(
    .MEM_BYTES (16384),
    .ADDR_WIDTH(16)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full transaction, started at posedge+1 while the DUT is idle.
  // resp_edge = index of the edge after which rsp_valid is first seen
  // (accept edge is 0), or -1 if no response within the budget.
  task automatic access(input logic wr, input logic [15:0] addr,
                        input logic [15:0] data, output logic [15:0] rdata,
                        output logic err, output int resp_edge);
    int n;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    resp_edge = 0;
    while (!bus.rsp_valid && resp_edge < 20) begin
      @(posedge clk); #1; resp_edge++;
    end
    if (!bus.rsp_valid) resp_edge = -1;
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    if (bus.rsp_rdata !== 16'h0000) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0000", bus.rsp_rdata); end
    if (bus.rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", bus.rsp_err); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    logic [15:0] rd; logic er; int le;
    access(1'b1, 16'h0010, 16'hBEEF, rd, er, le);
    checks += 3;
    if (er !== 1'b0) begin failures++; $display("FAIL st_beef_err got=%b exp=0", er); end
    if (rd !== 16'h0000) begin failures++; $display("FAIL st_beef_rdata got=%h exp=0000", rd); end
    if (le != 2) begin failures++; $display("FAIL st_beef_latency got=%0d exp=2", le); end
    checks += 2;
    if (dut.mem_q[16'h0010] !== 8'hEF) begin failures++; $display("FAIL peek_10 got=%h exp=ef", dut.mem_q[16'h0010]); end
    if (dut.mem_q[16'h0011] !== 8'hBE) begin failures++; $display("FAIL peek_11 got=%h exp=be", dut.mem_q[16'h0011]); end
    access(1'b0, 16'h0010, 16'h0000, rd, er, le);
    checks += 3;
    if (rd !== 16'hBEEF) begin failures++; $display("FAIL ld_beef_rdata got=%h exp=beef", rd); end
    if (er !== 1'b0) begin failures++; $display("FAIL ld_beef_err got=%b exp=0", er); end
    if (le != 2) begin failures++; $display("FAIL ld_beef_latency got=%0d exp=2", le); end
  endtask

  task automatic test_overlap();
    logic [15:0] rd; logic er; int le;
    access(1'b1, 16'h0002, 16'h0056, rd, er, le);  // mem[2]=56, mem[3]=00
    access(1'b1, 16'h0000, 16'h1234, rd, er, le);
    access(1'b0, 16'h0001, 16'h0000, rd, er, le);
    checks += 3;
`ifdef MEM_RESP_ALIGN_CHECK_EN
    if (rd !== 16'h0000) begin failures++; $display("FAIL odd_ld_rdata got=%h exp=0000", rd); end
    if (er !== 1'b1) begin failures++; $display("FAIL odd_ld_err got=%b exp=1", er); end
    if (le != 0) begin failures++; $display("FAIL odd_ld_latency got=%0d exp=0", le); end
`else
    if (rd !== 16'h5612) begin failures++; $display("FAIL odd_ld_rdata got=%h exp=5612", rd); end
    if (er !== 1'b0) begin failures++; $display("FAIL odd_ld_err got=%b exp=0", er); end
    if (le != 2) begin failures++; $display("FAIL odd_ld_latency got=%0d exp=2", le); end
`endif
  endtask

  task automatic test_range();
    logic [15:0] rd; logic er; int le;
    access(1'b1, 16'h3FFE, 16'h9900, rd, er, le);  // mem[3fff]=99
    access(1'b0, 16'h3FFE, 16'h0000, rd, er, le);
    checks += 2;
    if (rd !== 16'h9900) begin failures++; $display("FAIL top_legal_rdata got=%h exp=9900", rd); end
    if (le != 2) begin failures++; $display("FAIL top_legal_latency got=%0d exp=2", le); end
    access(1'b0, 16'h3FFF, 16'h0000, rd, er, le);
    checks += 3;
    if (er !== 1'b1) begin failures++; $display("FAIL oor_ld_err got=%b exp=1", er); end
    if (rd !== 16'h0000) begin failures++; $display("FAIL oor_ld_rdata got=%h exp=0000", rd); end
    if (le != 0) begin failures++; $display("FAIL oor_ld_latency got=%0d exp=0", le); end
    access(1'b1, 16'h3FFF, 16'h1177, rd, er, le);
    checks += 3;
    if (er !== 1'b1) begin failures++; $display("FAIL oor_st_err got=%b exp=1", er); end
    if (le != 0) begin failures++; $display("FAIL oor_st_latency got=%0d exp=0", le); end
    if (dut.mem_q[16'h3FFF] !== 8'h99) begin failures++; $display("FAIL oor_st_mem got=%h exp=99", dut.mem_q[16'h3FFF]); end
  endtask

  task automatic test_stall();
    logic [15:0] rd; logic er; int le; int n;
    access(1'b1, 16'h0030, 16'hA5A5, rd, er, le);
    bus.req_write = 1'b0; bus.req_addr = 16'h0030; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      checks += 3;
      if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", i, bus.rsp_valid); end
      if (bus.rsp_rdata !== 16'hA5A5) begin failures++; $display("FAIL stall_rdata cyc=%0d got=%h exp=a5a5", i, bus.rsp_rdata); end
      if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL stall_req_ready cyc=%0d got=%b exp=0", i, bus.req_ready); end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks += 3;
    if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL release_valid got=%b exp=0", bus.rsp_valid); end
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL release_req_ready got=%b exp=1", bus.req_ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL release_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; logic er; int le;
    int cyc; int acc0; int acc1; logic rr;
    cyc = 0; acc0 = -1; acc1 = -1;
    bus.rsp_ready = 1'b1;
    bus.req_write = 1'b1; bus.req_addr = 16'h0020; bus.req_wdata = 16'h0001;
    bus.req_valid = 1'b1;
    while (acc1 < 0 && cyc < 40) begin
      rr = bus.req_ready;
      @(posedge clk); #1; cyc++;
      if (rr) begin
        if (acc0 < 0) begin
          acc0 = cyc;
          bus.req_addr = 16'h0022; bus.req_wdata = 16'h0002;
        end else begin
          acc1 = cyc;
        end
      end
    end
    bus.req_valid = 1'b0;
    while (bus.rsp_valid !== 1'b1 && cyc < 60) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checks += 1;
    if (acc1 - acc0 != 4 || acc0 < 0) begin failures++; $display("FAIL b2b_spacing got=%0d exp=4", acc1 - acc0); end
    access(1'b0, 16'h0020, 16'h0000, rd, er, le);
    checks += 1;
    if (rd !== 16'h0001) begin failures++; $display("FAIL b2b_ld20 got=%h exp=0001", rd); end
    access(1'b0, 16'h0022, 16'h0000, rd, er, le);
    checks += 1;
    if (rd !== 16'h0002) begin failures++; $display("FAIL b2b_ld22 got=%h exp=0002", rd); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd; logic er; int le; int seen;
    access(1'b1, 16'h0040, 16'h7788, rd, er, le);  // mem[41]=77
    bus.req_write = 1'b1; bus.req_addr = 16'h0040; bus.req_wdata = 16'hCAFE;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;          // accept edge
    bus.req_valid = 1'b0;
    @(posedge clk); #1;          // BYTE0 writes the low byte
    reset_n = 1'b0;
    #1;
    checks += 3;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL midrst_req_ready got=%b exp=1", bus.req_ready); end
    if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_rsp_valid got=%b exp=0", bus.rsp_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    repeat (4) begin @(posedge clk); #1; if (bus.rsp_valid) seen++; end
    checks += 1;
    if (seen != 0) begin failures++; $display("FAIL midrst_no_rsp got=%0d exp=0", seen); end
    access(1'b0, 16'h0040, 16'h0000, rd, er, le);
    checks += 1;
    if (rd !== 16'h77FE) begin failures++; $display("FAIL midrst_ld40 got=%h exp=77fe", rd); end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset_n = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0;
    bus.req_addr = 16'h0000; bus.req_wdata = 16'h0000; bus.rsp_ready = 1'b0;
    #2;
    test_reset();
    test_store_load();
    test_overlap();
    test_range();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a sequence stalls unexpectedly.
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
